// File: rtl/dmem_bridge_if.sv
// Interfaces for dmem_bridge: CPU data port (CPU is master) and external
// request/acknowledge bus (bridge is master).
interface dmem_cpu_if;
    logic [31:0] i_addr;
    logic [3:0]  i_we;
    logic        i_rd;
    logic [31:0] i_data;
    logic        i_hold;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_err;

    modport master (
        output i_addr, i_we, i_rd, i_data, i_hold,
        input  o_valid, o_data, o_err
    );
    modport slave (
        input  i_addr, i_we, i_rd, i_data, i_hold,
        output o_valid, o_data, o_err
    );
endinterface

interface dmem_bus_if;
    logic        o_bus_req;
    logic [3:0]  o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    modport master (
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata,
        input  i_bus_ack, i_bus_rdata
    );
    modport slave (
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata,
        output i_bus_ack, i_bus_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// CPU data-port responder: one req/ack bus transaction per access, with bus timeout.
// Define DBRIDGE_WBUF_EN for a single-entry posted write buffer.
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    dmem_cpu_if.slave  cpu,
    dmem_bus_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               bus_req_q, bus_req_d;
    logic [3:0]         bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_wr, req, accept, tmo_hit, valid;

`ifdef DBRIDGE_WBUF_EN
    logic               posted_q, posted_d;
`endif

    assign is_wr = |cpu.i_we;
    assign req   = cpu.i_rd | is_wr;

`ifdef DBRIDGE_WBUF_EN
    // a write is only posted in a cycle where the CPU actually advances
    assign accept = !(is_wr && cpu.i_hold);
`else
    assign accept = 1'b1;
`endif

    // this BUS cycle is the TIMEOUT-th one
    assign tmo_hit = (TIMEOUT != 0) &&
                     (({1'b0, cnt_q} + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        data_d      = data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        valid       = 1'b0;
`ifdef DBRIDGE_WBUF_EN
        posted_d    = posted_q;
`endif
        case (state_q)
            IDLE: begin
                valid = !req;
                if (req && accept) begin
                    state_d     = BUS;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = cpu.i_addr & ~32'h3;
                    bus_we_d    = cpu.i_we;
                    bus_wdata_d = cpu.i_data;
                    cnt_d       = '0;
`ifdef DBRIDGE_WBUF_EN
                    posted_d    = is_wr;
                    valid       = is_wr;
`endif
                end
            end
            BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef DBRIDGE_WBUF_EN
                if (posted_q) valid = !req;
`endif
                if (bus.i_bus_ack) begin
                    data_d    = bus.i_bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else if (tmo_hit) begin
                    data_d    = '0;
                    err_d     = 1'b1;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end
`ifdef DBRIDGE_WBUF_EN
                // a drained posted write has no CPU waiting on it, skip DONE
                if (posted_q && (bus.i_bus_ack || tmo_hit)) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    posted_d = 1'b0;
                end
`endif
            end
            DONE: begin
                valid = 1'b1;
                if (!cpu.i_hold) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
`ifdef DBRIDGE_WBUF_EN
            posted_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
`ifdef DBRIDGE_WBUF_EN
            posted_q    <= posted_d;
`endif
        end
    end

    assign cpu.o_valid     = valid;
    assign cpu.o_data      = (state_q == DONE) ? data_q : '0;
    assign cpu.o_err       = err_q;
    assign bus.o_bus_req   = bus_req_q;
    assign bus.o_bus_we    = bus_we_q;
    assign bus.o_bus_addr  = bus_addr_q;
    assign bus.o_bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized bench for dmem_bridge against a transaction-level latency/data model.
module tb_dmem_bridge;
    localparam int unsigned TO = 4;
`ifdef DBRIDGE_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_cpu_if cpu_if();
    dmem_bus_if bus_if();

    dmem_bridge #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .cpu   (cpu_if.slave),
        .bus   (bus_if.master)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // stimulus presented on the next cycle
    logic [31:0] cur_addr = '0, cur_wd = '0;
    logic [3:0]  cur_we = '0;
    logic        cur_rd = 1'b0, cur_hold = 1'b0, cur_rst = 1'b1;

    // slave model state and expected bus fields of the current transaction
    int unsigned slave_wait = 1000;
    logic [31:0] slave_rdata = '0;
    int unsigned bus_cyc = 0, req_rises = 0;
    logic        req_prev = 1'b0, txn_end = 1'b0;
    logic [31:0] exp_baddr = '0, exp_bwd = '0;
    logic [3:0]  exp_bwe = '0;
    logic        err_model = 1'b0;

    task automatic slave_eval();
        if (bus_if.o_bus_req && !req_prev) begin
            req_rises++;
            bus_cyc = 0;
            txn_end = 1'b0;
        end
        if (!bus_if.o_bus_req && req_prev) txn_end = 1'b1;
        if (bus_if.o_bus_req) begin
            bus_cyc++;
            check("bus_addr", bus_if.o_bus_addr, exp_baddr);
            check("bus_we", 32'(bus_if.o_bus_we), 32'(exp_bwe));
            check("bus_wdata", bus_if.o_bus_wdata, exp_bwd);
            if (bus_cyc == slave_wait + 1) begin
                bus_if.i_bus_ack   = 1'b1;
                bus_if.i_bus_rdata = slave_rdata;
            end
        end
        req_prev = bus_if.o_bus_req;
    endtask

    task automatic cyc();
        @(negedge clk);
        rst                = cur_rst;
        cpu_if.i_addr      = cur_addr;
        cpu_if.i_we        = cur_we;
        cpu_if.i_rd        = cur_rd;
        cpu_if.i_data      = cur_wd;
        cpu_if.i_hold      = cur_hold;
        bus_if.i_bus_ack   = 1'b0;
        bus_if.i_bus_rdata = $urandom;
        #1;
        slave_eval();
    endtask

    task automatic idle_cycle();
        cur_rd = 1'b0; cur_we = '0; cur_hold = 1'b0;
        cyc();
        check("idle_valid", 32'(cpu_if.o_valid), 32'd1);
        check("idle_data", cpu_if.o_data, 32'd0);
        check("idle_req", 32'(bus_if.o_bus_req), 32'd0);
    endtask

    task automatic access(input logic [31:0] a, input logic [3:0] we, input logic rd,
                          input logic [31:0] wd, input int unsigned waits,
                          input int unsigned holds);
        logic        is_wr, tmo, posted;
        logic [31:0] rdata;
        int unsigned low, exp_low, guard, r0;
        is_wr  = (we != 4'd0);
        tmo    = (waits + 1 > TO);
        posted = WBUF && is_wr;
        rdata  = $urandom;
        r0     = req_rises;
        slave_wait  = waits;
        slave_rdata = rdata;
        exp_baddr   = a & ~32'h3;
        exp_bwe     = we;
        exp_bwd     = wd;
        exp_low     = posted ? 0 : (tmo ? TO + 1 : waits + 2);
        err_model   = err_model | tmo;

        cur_addr = a; cur_we = we; cur_rd = rd; cur_wd = wd;
        cur_hold = !posted && (holds != 0);
        low = 0;
        cyc();
        while (!cpu_if.o_valid && low < 100) begin
            check("busy_data", cpu_if.o_data, 32'd0);
            low++;
            cyc();
        end
        check("stall_cycles", low, exp_low);
        if (posted) begin
            cur_rd = 1'b0; cur_we = '0; cur_hold = 1'b0;
            guard = 0;
            do begin
                cyc();
                check("drain_valid", 32'(cpu_if.o_valid), 32'd1);
                guard++;
            end while (!txn_end && guard < 100);
            check("drain_end", 32'(txn_end), 32'd1);
        end else begin
            check("done_data", cpu_if.o_data, tmo ? 32'd0 : rdata);
            for (int unsigned i = 1; i <= holds; i++) begin
                cur_hold = (i < holds);
                cyc();
                check("hold_valid", 32'(cpu_if.o_valid), 32'd1);
                check("hold_data", cpu_if.o_data, tmo ? 32'd0 : rdata);
                check("hold_req", 32'(bus_if.o_bus_req), 32'd0);
            end
        end
        check("req_count", req_rises - r0, 32'd1);
        check("bus_len", bus_cyc, tmo ? TO : waits + 1);
        check("err", 32'(cpu_if.o_err), 32'(err_model));
        slave_wait = 1000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  we;
        logic        rd;
        int unsigned kind;

        cur_rst = 1'b1;
        cyc(); cyc();
        cur_rst = 1'b0;
        cyc();
        check("rst_valid", 32'(cpu_if.o_valid), 32'd1);
        check("rst_data", cpu_if.o_data, 32'd0);
        check("rst_err", 32'(cpu_if.o_err), 32'd0);
        check("rst_req", 32'(bus_if.o_bus_req), 32'd0);
        check("rst_we", 32'(bus_if.o_bus_we), 32'd0);
        check("rst_addr", bus_if.o_bus_addr, 32'd0);
        check("rst_wdata", bus_if.o_bus_wdata, 32'd0);

        // directed: read with 3 waits (ack lands on the timeout cycle), write, hold, rd+we
        access(32'h0000_1006, 4'b0000, 1'b1, 32'h1234_5678, 3, 0);
        access(32'h0000_0020, 4'b0011, 1'b0, 32'h0000_BEEF, 0, 0);
        access(32'h0000_0444, 4'b0000, 1'b1, 32'h0, 1, 4);
        idle_cycle();
        access(32'h0000_0088, 4'b1111, 1'b1, 32'hA5A5_5A5A, 2, 1);

        // ack outside BUS must be ignored
        idle_cycle();
        bus_if.i_bus_ack   = 1'b1;
        bus_if.i_bus_rdata = 32'hDEAD_0001;
        idle_cycle();

        // timeout, then err stays sticky
        access(32'h0000_0100, 4'b0000, 1'b1, 32'h0, 10, 2);
        access(32'h0000_0104, 4'b0000, 1'b1, 32'h0, 0, 0);

        for (int unsigned n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            we   = (kind == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            rd   = (kind != 1);
            access($urandom, we, rd, $urandom, $urandom_range(0, 6), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // reset while in BUS, late ack afterwards
        slave_wait = 1000;
        cur_addr = 32'h0000_2003; cur_we = '0; cur_rd = 1'b1; cur_wd = 32'h0; cur_hold = 1'b0;
        exp_baddr = 32'h0000_2000; exp_bwe = '0; exp_bwd = 32'h0;
        cyc(); cyc(); cyc();
        check("pre_rst_req", 32'(bus_if.o_bus_req), 32'd1);
        cur_rd = 1'b0; cur_rst = 1'b1;
        cyc();
        cur_rst = 1'b0;
        err_model = 1'b0;
        cyc();
        bus_if.i_bus_ack   = 1'b1;
        bus_if.i_bus_rdata = 32'hBAD0_BAD0;
        check("mrst_req", 32'(bus_if.o_bus_req), 32'd0);
        check("mrst_valid", 32'(cpu_if.o_valid), 32'd1);
        check("mrst_data", cpu_if.o_data, 32'd0);
        check("mrst_err", 32'(cpu_if.o_err), 32'd0);
        idle_cycle();

        for (int unsigned n = 0; n < 10; n++) begin
            kind = $urandom_range(0, 2);
            we   = (kind == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            rd   = (kind != 1);
            access($urandom, we, rd, $urandom, $urandom_range(0, 5), $urandom_range(0, 2));
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Responder for the CPU data-memory port. Consumes address, byte-enables, read strobe and write data. Returns read data and a combinational valid that stalls the pipeline.
- Converts each CPU access into one transaction on a slower external request/acknowledge bus.
- Sits between the CPU data port and the SoC data bus/SRAM controller.
- Includes a bus timeout so a dead slave cannot hang the core.

Parameters:
- TIMEOUT, 255, cycles in BUS state without i_bus_ack before the access is aborted. 0 disables the timeout.
- CNT_W, 8, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_addr  in  32  CPU data address; bits [1:0] ignored on the bus side
- i_we  in  4  CPU byte write enables
- i_rd  in  1  CPU read strobe
- i_data  in  32  CPU write data, already lane-aligned
- i_hold  in  1  pipeline held by another stall source (instruction side, ALU busy); high means the CPU will not advance this cycle
- o_valid  out  1  combinational; data side ready, CPU may advance
- o_data  out  32  read data to CPU
- o_err  out  1  sticky timeout flag; cleared only by reset
- o_bus_req  out  1  bus request, registered
- o_bus_we  out  4  bus byte enables; 0 means read
- o_bus_addr  out  32  word address {addr[31:2],2'b00}
- o_bus_wdata  out  32  bus write data
- i_bus_ack  in  1  slave acknowledge, single-cycle pulse
- i_bus_rdata  in  32  slave read data, valid with i_bus_ack

Behaviour:
- Request condition: req = i_rd | (|i_we). If both are set, the access is a write and i_rd is ignored.
- Reset values: state IDLE; o_bus_req=0; o_bus_we=0; o_bus_addr=0; o_bus_wdata=0; o_data=0; o_err=0; timeout counter=0. After reset o_valid=1 whenever req=0.
- State machine: IDLE, BUS, DONE.
- IDLE:
  - o_valid = !req.
  - When req=1: latch word address, i_we and i_data into the bus registers; go to BUS. o_bus_req rises on the next cycle.
- BUS:
  - o_valid=0; o_bus_req=1 with address, byte enables and write data held stable.
  - Counter increments every cycle.
  - On i_bus_ack: capture i_bus_rdata into o_data (writes capture as well; the CPU ignores the value); drop o_bus_req next cycle; go to DONE.
  - When the counter reaches TIMEOUT with no ack: drop o_bus_req; set o_err; o_data=32'h0; go to DONE.
  - If ack and timeout occur in the same cycle, the ack wins and o_err stays 0.
- DONE:
  - o_valid=1; o_data is held.
  - If i_hold=0: go to IDLE; counter clears.
  - If i_hold=1: stay in DONE. The same request is still present, so it must not be re-issued.
- Latency with no wait states (ack in the first BUS cycle): req seen at cycle 0; o_bus_req=1 at cycle 1; DONE at cycle 2 (o_valid=1). Each extra slave wait cycle adds 1.
- Back-to-back accesses: the request following DONE is handled in IDLE in the very next cycle. There is no idle bubble beyond the IDLE evaluation.
- i_bus_ack outside BUS is ignored.
- Reset mid-access: the next state is IDLE and o_bus_req is 0. A late ack is ignored.
- o_data is 0 in IDLE and BUS; it changes only on ack, timeout or reset.

Optional Feature:
- Macro DBRIDGE_WBUF_EN: single-entry posted write buffer.
- With the macro defined:
  - A write seen in IDLE with the buffer empty is accepted only in a cycle with i_hold=0. o_valid=1 in that same cycle, and address, byte enables and data are stored into the buffer.
  - The buffer then drains on the bus via BUS with o_valid unaffected until the next request.
  - A write seen with i_hold=1 is not captured; it is re-presented later.
  - Any request (read or write) arriving while the buffer is non-empty sees o_valid=0 until the drain ack, then is processed normally.
  - Reads never bypass the buffer.
  - A timeout during drain sets o_err and discards the write.
- Without the macro: writes wait for the ack exactly like reads.

Test Plan:
1. Read, ack after 3 wait cycles: i_addr=0x0000_1006, i_rd=1; slave returns 0xCAFEBABE -> o_bus_addr=0x0000_1004, o_bus_we=0, o_valid low for 5 cycles, then o_valid=1 and o_data=0xCAFEBABE for one cycle with i_hold=0.
2. Write: i_addr=0x20, i_we=4'b0011, i_data=0x0000_BEEF; ack in the first BUS cycle -> o_bus_we=4'b0011, o_bus_wdata=0x0000_BEEF, o_valid=1 at cycle 2. With DBRIDGE_WBUF_EN: o_valid=1 at cycle 0 and the bus transaction still occurs.
3. Hold in DONE: complete a read, then keep i_hold=1 for 4 cycles -> exactly one o_bus_req assertion, o_valid=1 and o_data stable for all 4 cycles, then IDLE.
4. Timeout: TIMEOUT=4, read with no ack -> o_bus_req high 4 cycles then low, o_err=1 sticky, o_data=0, o_valid=1 in DONE.
5. Reset mid-access: i_rst=1 while in BUS, ack one cycle after reset -> o_bus_req=0 after reset, state IDLE, ack ignored, o_data=0.
6. Simultaneous i_rd=1 and i_we=4'b1111 -> treated as a write, o_bus_we=4'b1111.
